// File: rtl/cmos_capture_pkg.sv
// Shared state encoding, byte-phase constants and default geometry for the
// CMOS RGB565 capture path.
package cmos_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_ACTIVE = 2'd2
  } capState_e;

  localparam logic PHASE_HI = 1'b0;
  localparam logic PHASE_LO = 1'b1;

  localparam int DEF_FRAME_SKIP = 10;
  localparam int DEF_H_PIXELS   = 640;
  localparam int DEF_V_LINES    = 480;

  localparam int PIX_CNT_W  = 11;
  localparam int LINE_CNT_W = 10;
  localparam int SKIP_CNT_W = 16;

endpackage

// File: rtl/cmos_byte_pack.sv
// Pairs sensor bytes (high byte first) into RGB565 pixels and emits a one-cycle
// strobe with each completed pixel; an unpaired trailing byte is dropped.
module cmos_byte_pack
  import cmos_capture_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        href_i,
  input  logic [7:0]  data_i,
  output logic [15:0] pixel_o,
  output logic        strobe_o,
  output logic        pairDone_o
);

  logic        phase_q, phase_d;
  logic [7:0]  hiByte_q, hiByte_d;
  logic [15:0] pixel_q, pixel_d;
  logic        strobe_q, strobe_d;

  // The pixel register only loads on a strobe, so the output holds between pixels.
  always_comb begin
    phase_d    = PHASE_HI;
    hiByte_d   = hiByte_q;
    pixel_d    = pixel_q;
    strobe_d   = 1'b0;
    pairDone_o = 1'b0;
    if (href_i) begin
      phase_d = ~phase_q;
      if (phase_q == PHASE_HI) begin
        hiByte_d = data_i;
      end else begin
        pairDone_o = 1'b1;
        if (enable_i) begin
          strobe_d = 1'b1;
          pixel_d  = {hiByte_q, data_i};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q  <= PHASE_HI;
      hiByte_q <= '0;
      pixel_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hiByte_q <= hiByte_d;
      pixel_q  <= pixel_d;
      strobe_q <= strobe_d;
    end
  end

  assign pixel_o  = pixel_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/cmos_capture_rgb565.sv
// CMOS sensor capture front end: skips FRAME_SKIP frames after SDRAM init,
// then strobes assembled RGB565 pixels and checks line/frame geometry.
module cmos_capture_rgb565
  import cmos_capture_pkg::*;
#(
  parameter int FRAME_SKIP = DEF_FRAME_SKIP,
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_LINES    = DEF_V_LINES
) (
  input  logic        clk_cmos,
  input  logic        rst,
  input  logic        sdram_init_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        cmos_frame_clken,
  output logic [15:0] cmos_frame_data,
  output logic        cmos_frame_valid,
  output logic [7:0]  frame_cnt,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [31:0]           SKIP_TARGET = 32'(FRAME_SKIP);
  localparam logic [PIX_CNT_W-1:0]  H_TARGET    = PIX_CNT_W'(H_PIXELS);
  localparam logic [LINE_CNT_W-1:0] V_TARGET    = LINE_CNT_W'(V_LINES);

  logic       vsync_q, vsyncDly_q, href_q, hrefDly_q;
  logic [7:0] data_q;

  capState_e state_q, state_d;
  logic captureActive, skipping;

  logic [SKIP_CNT_W-1:0] skipCnt_q, skipCnt_d;
  logic [PIX_CNT_W-1:0]  pixCnt_q, pixCnt_d;
  logic [LINE_CNT_W-1:0] lineCnt_q, lineCnt_d;
  logic [7:0]            frameCnt_q, frameCnt_d;
  logic                  frameValid_q, frameValid_d;

  logic frameStart, frameEnd, lineStart, lineEnd, skipDone, inFrame;
  logic packEnable, pairDone;

  // Sensor pins are sampled once; the delayed copies give edge detection.
  always_ff @(posedge clk_cmos or posedge rst) begin
    if (rst) begin
      vsync_q    <= 1'b0;
      vsyncDly_q <= 1'b0;
      href_q     <= 1'b0;
      hrefDly_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      vsync_q    <= cmos_vsync;
      vsyncDly_q <= vsync_q;
      href_q     <= cmos_href;
      hrefDly_q  <= href_q;
      data_q     <= cmos_data;
    end
  end

  assign frameStart = vsyncDly_q & ~vsync_q;
  assign frameEnd   = ~vsyncDly_q & vsync_q;
  assign lineStart  = href_q & ~hrefDly_q;
  assign lineEnd    = hrefDly_q & ~href_q;
  assign skipDone   = (32'(skipCnt_q) + 32'd1) >= SKIP_TARGET;

  always_ff @(posedge clk_cmos or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (sdram_init_done) state_d = ST_SKIP;
      ST_SKIP: begin
        if (!sdram_init_done)          state_d = ST_IDLE;
        else if (frameEnd && skipDone) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: if (!sdram_init_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    captureActive = 1'b0;
    skipping      = 1'b0;
    unique case (state_q)
      ST_SKIP:   skipping      = 1'b1;
      ST_ACTIVE: captureActive = 1'b1;
      default:   ;
    endcase
  end

  // A frame only becomes valid on a fresh frame start, so a partial frame at
  // ACTIVE entry is never captured.
  always_comb begin
    skipCnt_d    = '0;
    pixCnt_d     = pixCnt_q;
    lineCnt_d    = lineCnt_q;
    frameCnt_d   = frameCnt_q;
    frameValid_d = frameValid_q;

    if (skipping) skipCnt_d = frameEnd ? skipCnt_q + SKIP_CNT_W'(1) : skipCnt_q;

    if (lineStart)                     pixCnt_d = '0;
    else if (pairDone && pixCnt_q != '1) pixCnt_d = pixCnt_q + PIX_CNT_W'(1);

    if (frameStart)                       lineCnt_d = '0;
    else if (lineEnd && lineCnt_q != '1)  lineCnt_d = lineCnt_q + LINE_CNT_W'(1);

    if (!sdram_init_done || !captureActive) frameValid_d = 1'b0;
    else if (frameStart)                    frameValid_d = 1'b1;
    else if (frameEnd)                      frameValid_d = 1'b0;

    if (captureActive && frameValid_q && frameEnd) frameCnt_d = frameCnt_q + 8'd1;
  end

  always_ff @(posedge clk_cmos or posedge rst) begin
    if (rst) begin
      skipCnt_q    <= '0;
      pixCnt_q     <= '0;
      lineCnt_q    <= '0;
      frameCnt_q   <= '0;
      frameValid_q <= 1'b0;
    end else begin
      skipCnt_q    <= skipCnt_d;
      pixCnt_q     <= pixCnt_d;
      lineCnt_q    <= lineCnt_d;
      frameCnt_q   <= frameCnt_d;
      frameValid_q <= frameValid_d;
    end
  end

  assign inFrame    = captureActive & frameValid_q;
  assign packEnable = inFrame & sdram_init_done;

  cmos_byte_pack uPack (
    .clk_i      (clk_cmos),
    .rst_i      (rst),
    .enable_i   (packEnable),
    .href_i     (href_q),
    .data_i     (data_q),
    .pixel_o    (cmos_frame_data),
    .strobe_o   (cmos_frame_clken),
    .pairDone_o (pairDone)
  );

  assign cmos_frame_valid = frameValid_q;
  assign frame_cnt        = frameCnt_q;
  assign line_err         = inFrame & lineEnd & (pixCnt_q != H_TARGET);
  assign frame_err        = inFrame & frameEnd & (lineCnt_q != V_TARGET);

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Self-checking bench for cmos_capture_rgb565 with a small geometry
// (skip 2 frames, 4-pixel lines, 2-line frames).
module tb_cmos_capture_rgb565;

  localparam int FRAME_SKIP = 2;
  localparam int H_PIXELS   = 4;
  localparam int V_LINES    = 2;

  logic        clk_cmos = 1'b0;
  logic        rst;
  logic        sdram_init_done;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic        cmos_frame_clken;
  logic [15:0] cmos_frame_data;
  logic        cmos_frame_valid;
  logic [7:0]  frame_cnt;
  logic        line_err;
  logic        frame_err;

  always #5 clk_cmos = ~clk_cmos;

  cmos_capture_rgb565 #(
    .FRAME_SKIP (FRAME_SKIP),
    .H_PIXELS   (H_PIXELS),
    .V_LINES    (V_LINES)
  ) dut (
    .clk_cmos         (clk_cmos),
    .rst              (rst),
    .sdram_init_done  (sdram_init_done),
    .cmos_vsync       (cmos_vsync),
    .cmos_href        (cmos_href),
    .cmos_data        (cmos_data),
    .cmos_frame_clken (cmos_frame_clken),
    .cmos_frame_data  (cmos_frame_data),
    .cmos_frame_valid (cmos_frame_valid),
    .frame_cnt        (frame_cnt),
    .line_err         (line_err),
    .frame_err        (frame_err)
  );

  typedef struct {
    int lines;
    int bytes;
    int expStrobes;
    int expLineErr;
    int expFrameErr;
  } frameVec_t;

  frameVec_t vecs[6];

  int checks   = 0;
  int failures = 0;

  logic [15:0] expPix[$];
  int strobeTotal   = 0;
  int lineErrTotal  = 0;
  int frameErrTotal = 0;
  int snapStrobe, snapLineErr, snapFrameErr;
  int endsSinceArm  = 0;
  int mdlFrameCnt   = 0;

  logic        sClken, sValid, sLineErr, sFrameErr;
  logic [15:0] sData;
  logic [7:0]  sCnt;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sample outputs on the falling edge, then drive the next pin values.
  task automatic applyStimulus(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk_cmos);
    sClken    = cmos_frame_clken;
    sData     = cmos_frame_data;
    sValid    = cmos_frame_valid;
    sLineErr  = line_err;
    sFrameErr = frame_err;
    sCnt      = frame_cnt;
    if (sLineErr)  lineErrTotal++;
    if (sFrameErr) frameErrTotal++;
    if (sClken) begin
      strobeTotal++;
      if (expPix.size() == 0) checkOutput("unexpected_strobe", 32'(sClken), 32'd0);
      else                    checkOutput("pixel_data", 32'(sData), 32'(expPix.pop_front()));
    end
    cmos_vsync = vs;
    cmos_href  = hr;
    cmos_data  = d;
  endtask

  function automatic void frameModel(input int lines, input int bytes, input bit cap,
                                     output int s, output int le, output int fe);
    if (!cap) begin
      s = 0; le = 0; fe = 0;
    end else begin
      s  = lines * (bytes / 2);
      le = ((bytes / 2) != H_PIXELS) ? lines : 0;
      fe = (lines != V_LINES) ? 1 : 0;
    end
  endfunction

  task automatic snapshot();
    snapStrobe   = strobeTotal;
    snapLineErr  = lineErrTotal;
    snapFrameErr = frameErrTotal;
  endtask

  task automatic startFrame(output bit cap);
    if (cmos_vsync == 1'b0) endsSinceArm++;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    cap = (endsSinceArm >= FRAME_SKIP);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("valid_after_start", 32'(sValid), 32'(cap));
  endtask

  task automatic driveLine(input int nBytes, input bit cap);
    logic [7:0] hi;
    logic [7:0] d;
    hi = 8'h00;
    for (int b = 0; b < nBytes; b++) begin
      d = 8'($urandom_range(0, 255));
      if (b % 2 == 0) hi = d;
      else if (cap)   expPix.push_back({hi, d});
      applyStimulus(1'b0, 1'b1, d);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic endFrame(input string tag, input int eS, input int eL, input int eF, input bit cap);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput({tag, "_frame_err_at_end"}, 32'(sFrameErr), 32'(eF));
    checkOutput({tag, "_valid_at_end"}, 32'(sValid), 32'(cap));
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput({tag, "_valid_after_end"}, 32'(sValid), 32'd0);
    if (cap) mdlFrameCnt = (mdlFrameCnt + 1) % 256;
    checkOutput({tag, "_frame_cnt"}, 32'(sCnt), 32'(mdlFrameCnt));
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput({tag, "_strobes"}, 32'(strobeTotal - snapStrobe), 32'(eS));
    checkOutput({tag, "_line_errs"}, 32'(lineErrTotal - snapLineErr), 32'(eL));
    checkOutput({tag, "_frame_errs"}, 32'(frameErrTotal - snapFrameErr), 32'(eF));
    checkOutput({tag, "_pixels_left"}, 32'(expPix.size()), 32'd0);
    endsSinceArm++;
  endtask

  task automatic runFrame(input string tag, input int lines, input int bytes,
                          input bit useTable, input frameVec_t v);
    bit cap;
    int s, le, fe;
    snapshot();
    startFrame(cap);
    for (int l = 0; l < lines; l++) driveLine(bytes, cap);
    frameModel(lines, bytes, cap, s, le, fe);
    if (useTable && cap) begin
      s = v.expStrobes; le = v.expLineErr; fe = v.expFrameErr;
    end
    endFrame(tag, s, le, fe, cap);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit cap;
    frameVec_t none;
    int rl, rb;

    vecs[0] = '{lines: 2, bytes: 8,  expStrobes: 8,  expLineErr: 0, expFrameErr: 0};
    vecs[1] = '{lines: 2, bytes: 5,  expStrobes: 4,  expLineErr: 2, expFrameErr: 0};
    vecs[2] = '{lines: 3, bytes: 8,  expStrobes: 12, expLineErr: 0, expFrameErr: 1};
    vecs[3] = '{lines: 1, bytes: 10, expStrobes: 5,  expLineErr: 1, expFrameErr: 1};
    vecs[4] = '{lines: 2, bytes: 7,  expStrobes: 6,  expLineErr: 2, expFrameErr: 0};
    vecs[5] = '{lines: 0, bytes: 8,  expStrobes: 0,  expLineErr: 0, expFrameErr: 1};
    none    = '{lines: 0, bytes: 0,  expStrobes: 0,  expLineErr: 0, expFrameErr: 0};

    // Reset with busy pins: every output must stay zero.
    rst = 1'b1; sdram_init_done = 1'b0;
    cmos_vsync = 1'b1; cmos_href = 1'b1; cmos_data = 8'hAA;
    repeat (4) @(negedge clk_cmos);
    checkOutput("reset_clken", 32'(cmos_frame_clken), 32'd0);
    checkOutput("reset_data",  32'(cmos_frame_data),  32'd0);
    checkOutput("reset_valid", 32'(cmos_frame_valid), 32'd0);
    checkOutput("reset_cnt",   32'(frame_cnt),        32'd0);
    checkOutput("reset_lerr",  32'(line_err),         32'd0);
    checkOutput("reset_ferr",  32'(frame_err),        32'd0);
    cmos_href = 1'b0; cmos_data = 8'h00;
    @(negedge clk_cmos);
    rst = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    sdram_init_done = 1'b1;
    endsSinceArm = 0;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);

    // Two skipped 4x2 frames, then the table of captured frames.
    runFrame("skip1", 2, 8, 1'b0, none);
    runFrame("skip2", 2, 8, 1'b0, none);
    for (int i = 0; i < 6; i++) runFrame($sformatf("vec%0d", i), vecs[i].lines, vecs[i].bytes, 1'b1, vecs[i]);

    // Latency: 0xF8 then 0x1F gives 0xF81F two cycles after the low byte.
    snapshot();
    startFrame(cap);
    if (cap) expPix.push_back(16'hF81F);
    applyStimulus(1'b0, 1'b1, 8'hF8);
    applyStimulus(1'b0, 1'b1, 8'h1F);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("latency_n1_clken", 32'(sClken), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("latency_n2_clken", 32'(sClken), 32'd1);
    checkOutput("latency_n2_data",  32'(sData),  32'h0000F81F);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("hold_clken", 32'(sClken), 32'd0);
    checkOutput("hold_data",  32'(sData),  32'h0000F81F);
    driveLine(8, cap);
    endFrame("latency", 5, 1, 0, cap);

    // SDRAM ready dropped mid-line.
    snapshot();
    startFrame(cap);
    begin
      logic [7:0] b0, b1;
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      expPix.push_back({b0, b1});
      applyStimulus(1'b0, 1'b1, b0);
      applyStimulus(1'b0, 1'b1, b1);
      applyStimulus(1'b0, 1'b1, 8'h12);
      applyStimulus(1'b0, 1'b1, 8'h34);
    end
    sdram_init_done = 1'b0;
    applyStimulus(1'b0, 1'b1, 8'h56);
    checkOutput("drop_clken", 32'(sClken), 32'd0);
    checkOutput("drop_valid", 32'(sValid), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    endFrame("sdram_drop", 1, 0, 0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    sdram_init_done = 1'b1;
    endsSinceArm = 0;
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    runFrame("reskip1", 2, 8, 1'b0, none);
    runFrame("reskip2", 2, 8, 1'b0, none);
    runFrame("recapture", 2, 8, 1'b0, none);

    // Reset pulsed mid-frame while capturing.
    snapshot();
    startFrame(cap);
    driveLine(8, cap);
    applyStimulus(1'b0, 1'b1, 8'h77);
    rst = 1'b1;
    #1;
    checkOutput("midrst_clken", 32'(cmos_frame_clken), 32'd0);
    checkOutput("midrst_data",  32'(cmos_frame_data),  32'd0);
    checkOutput("midrst_valid", 32'(cmos_frame_valid), 32'd0);
    checkOutput("midrst_cnt",   32'(frame_cnt),        32'd0);
    checkOutput("midrst_lerr",  32'(line_err),         32'd0);
    checkOutput("midrst_ferr",  32'(frame_err),        32'd0);
    expPix.delete();
    mdlFrameCnt  = 0;
    endsSinceArm = 0;
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    runFrame("postrst1", 2, 8, 1'b0, none);
    runFrame("postrst2", 2, 8, 1'b0, none);

    // Randomized frame shapes against the frame-level model.
    for (int i = 0; i < 8; i++) begin
      rl = $urandom_range(0, 3);
      rb = $urandom_range(1, 10);
      runFrame($sformatf("rand%0d", i), rl, rb, 1'b0, none);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
